// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory responder: one outstanding load/store over valid/ready,
// completed exactly LATENCY edges after acceptance with a one-cycle response pulse.
module data_mem_responder #(
   parameter int unsigned LATENCY    = 4,
   parameter int unsigned DEPTH_LOG2 = 15
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_wr,
   input  logic [15:0] req_addr,
   input  logic [15:0] req_wdata,
   output logic        rsp_valid,
   output logic        rsp_wr,
   output logic [15:0] rsp_rdata
);

   localparam int unsigned DW    = 16;
   localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
   localparam int unsigned CW    = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   typedef enum logic {IDLE, BUSY} state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [CW-1:0]         r_cnt;
   logic [CW-1:0]         w_cnt_nxt;
   logic                  r_req_ready;
   logic                  w_req_ready_nxt;
   logic                  r_rsp_valid;
   logic                  w_rsp_valid_nxt;
   logic                  r_rsp_wr;
   logic [DW-1:0]         r_rsp_rdata;
   logic                  w_accept;
   logic                  w_complete;

   logic                  r_wr;
   logic [DEPTH_LOG2-1:0] r_idx;
   logic [DW-1:0]         r_wdata;
   logic [DW-1:0]         r_mem [DEPTH];

   assign req_ready = r_req_ready;
   assign rsp_valid = r_rsp_valid;
   assign rsp_wr    = r_rsp_wr;
   assign rsp_rdata = r_rsp_rdata;

   // State register and registered handshake/response outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_req_ready <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_rsp_wr    <= 1'b0;
         r_rsp_rdata <= '0;
         r_wr        <= 1'b0;
         r_idx       <= '0;
         r_wdata     <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_cnt       <= w_cnt_nxt;
         r_req_ready <= w_req_ready_nxt;
         r_rsp_valid <= w_rsp_valid_nxt;
         if (w_accept) begin
            r_wr    <= req_wr;
            r_idx   <= req_addr[DEPTH_LOG2:1];
            r_wdata <= req_wdata;
         end
         if (w_complete) begin
            r_rsp_wr <= r_wr;
            if (!r_wr) r_rsp_rdata <= r_mem[r_idx];
         end
      end
   end

   // Backing array is never cleared; a reset drops r_state to IDLE so no late write lands
   always_ff @(posedge clk) begin
      if (w_complete && r_wr) r_mem[r_idx] <= r_wdata;
   end

   // Next-state and handshake decode
   always_comb begin
      w_state_nxt     = r_state;
      w_cnt_nxt       = r_cnt;
      w_req_ready_nxt = r_req_ready;
      w_rsp_valid_nxt = 1'b0;
      w_accept        = 1'b0;
      w_complete      = 1'b0;
      case (r_state)
         IDLE: begin
            w_req_ready_nxt = 1'b1;
            if (req_valid && r_req_ready) begin
               w_accept        = 1'b1;
               w_cnt_nxt       = CW'(LATENCY - 1);
               w_req_ready_nxt = 1'b0;
               w_state_nxt     = BUSY;
            end
         end
         BUSY: begin
            w_req_ready_nxt = 1'b0;
            if (r_cnt != '0) begin
               w_cnt_nxt = r_cnt - CW'(1);
            end else begin
               w_complete      = 1'b1;
               w_rsp_valid_nxt = 1'b1;
               w_req_ready_nxt = 1'b1;
               w_state_nxt     = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

endmodule
